uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter acting as a responder on the CPU's unified memory bus
//  (mem_addr/mem_wdata/mem_wstrb/mem_rstrb/mem_rdata). The CPU writes bytes into a TX FIFO.
//  A baud-rate FSM serialises them as 8N1 frames on uart_tx, which goes to the board's PC-bound UART pin.
//  The top-level address decode drives sel; read data returns to the CPU through the top-level rdata mux.

---
 rtl/uart_tx_mmio.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO.
// The CPU pushes bytes through TXDATA. A baud-rate FSM drains the FIFO onto
// uart_tx, LSB first, one start bit and one stop bit per byte.
module uart_tx_mmio #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned       DEPTH      = 1 << FIFO_AW;
  localparam logic [15:0]       DIV_RESET  = 16'(CLK_HZ / BAUD);
  localparam logic [15:0]       DIV_MIN    = 16'd2;
  localparam logic [FIFO_AW:0]  FIFO_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]  CNT_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Storage and state registers
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [FIFO_AW:0]   count_q,    count_d;
  logic               overrun_q,  overrun_d;
  logic [15:0]        baud_div_q, baud_div_d;
  logic               ie_q,       ie_d;
  state_e             state_q,    state_d;
  logic [7:0]         shift_q,    shift_d;
  logic [2:0]         bit_idx_q,  bit_idx_d;
  logic [15:0]        timer_q,    timer_d;
  logic [15:0]        div_q,      div_d;
  logic               tx_q,       tx_d;
  logic [31:0]        rdata_q,    rdata_d;

  // Decode and handshake signals
  logic [1:0]  reg_sel;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push_req;
  logic        push_ok;
  logic        push_drop;
  logic        pop;
  logic        overrun_clr;
  logic        baud_wr;
  logic [15:0] baud_merged;
  logic [31:0] status_word;
  logic        unused_bits;

  assign reg_sel     = mem_addr[3:2];
  assign fifo_full   = (count_q == FIFO_FULL);
  assign fifo_empty  = (count_q == '0);
  assign pop         = (state_q == ST_IDLE) && !fifo_empty;
  assign push_req    = sel && mem_wstrb[0] && (reg_sel == REG_TXDATA);
  // A full FIFO still accepts a byte when the FSM frees a slot in the same cycle.
  assign push_ok     = push_req && (!fifo_full || pop);
  assign push_drop   = push_req && fifo_full && !pop;
  assign overrun_clr = sel && mem_wstrb[0] && (reg_sel == REG_STATUS) && mem_wdata[3];
  assign baud_wr     = sel && (|mem_wstrb[1:0]) && (reg_sel == REG_BAUD);
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

  // FIFO payload storage, written on accepted pushes
  // NOTE: the data array has no reset; count/pointers alone define validity,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
    end
  end

  // FIFO pointers, occupancy and overrun flag
  // NOTE: every variable gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push_drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // BAUD_DIV and CTRL register writes; divisors below 2 are clamped
  always_comb begin
    baud_merged = baud_div_q;
    if (mem_wstrb[0]) baud_merged[7:0]  = mem_wdata[7:0];
    if (mem_wstrb[1]) baud_merged[15:8] = mem_wdata[15:8];
    baud_div_d = baud_div_q;
    if (baud_wr) begin
      baud_div_d = (baud_merged < DIV_MIN) ? DIV_MIN : baud_merged;
    end
    ie_d = ie_q;
    if (sel && mem_wstrb[0] && (reg_sel == REG_CTRL)) begin
      ie_d = mem_wdata[0];
    end
  end

  // Transmit FSM: next state, bit timer, shift register and registered line level
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    timer_d   = timer_q;
    div_d     = div_q;
    tx_d      = tx_q;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = fifo_mem[rd_ptr_q];
          div_d   = baud_div_q;
          timer_d = baud_div_q - 16'd1;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (timer_q == '0) begin
          state_d   = ST_DATA;
          timer_d   = div_q - 16'd1;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (timer_q == '0) begin
          timer_d = div_q - 16'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Read mux; mem_rdata holds its value unless a selected read strobe arrives
  always_comb begin
    status_word                   = '0;
    status_word[0]                = (state_q != ST_IDLE);
    status_word[1]                = fifo_full;
    status_word[2]                = fifo_empty;
    status_word[3]                = overrun_q;
    status_word[8 +: FIFO_AW + 1] = count_q;
    rdata_d = rdata_q;
    if (sel && mem_rstrb) begin
      unique case (reg_sel)
        REG_TXDATA: rdata_d = '0;
        REG_STATUS: rdata_d = status_word;
        REG_BAUD:   rdata_d = {16'd0, baud_div_q};
        REG_CTRL:   rdata_d = {31'd0, ie_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  // State register for everything except the FIFO payload
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      baud_div_q <= DIV_RESET;
      ie_q       <= 1'b0;
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      timer_q    <= '0;
      div_q      <= DIV_RESET;
      tx_q       <= 1'b1;
      rdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      baud_div_q <= baud_div_d;
      ie_q       <= ie_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
      rdata_q    <= rdata_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign uart_tx   = tx_q;
  assign irq       = fifo_empty && (state_q == ST_IDLE) && ie_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio.
// Inputs change on the falling clock edge; outputs are sampled on falling edges.
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        uart_tx;
  logic        irq;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;

  uart_tx_mmio dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .uart_tx   (uart_tx),
    .irq       (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level for frame slot k: 0 start, 1..8 data LSB first, 9 stop
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    sel = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    @(negedge clk);
    sel = 1'b0; mem_wstrb = '0; mem_wdata = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; mem_addr = a; mem_rstrb = 1'b1;
    @(negedge clk);
    sel = 1'b0; mem_rstrb = 1'b0;
    d = mem_rdata;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got=%b want=1", uart_tx); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h want=0", mem_rdata); end
    bus_write(4'h0, 32'h00, 4'b0001);
    repeat (10) @(negedge clk);
    n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL midframe_start got=%b want=0", uart_tx); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL async_reset_tx got=%b want=1", uart_tx); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(4'h4, d);
    n_cmp++; if (d !== 32'h0000_0004) begin n_bad++; $display("FAIL reset_status got=%h want=00000004", d); end
    bus_read(4'h8, d);
    n_cmp++; if (d !== 32'd868) begin n_bad++; $display("FAIL reset_baud got=%0d want=868", d); end
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_idle_tx got=%b want=1", uart_tx); end
  endtask

  task automatic test_single_frame();
    bus_write(4'h8, 32'd4, 4'b0011);
    bus_write(4'h0, 32'hA5, 4'b0001);
    sel = 1'b1; mem_addr = 4'h4; mem_rstrb = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if (uart_tx !== frame_bit(8'hA5, i / 4)) begin
        n_bad++; $display("FAIL frame_a5 slot=%0d got=%b want=%b", i, uart_tx, frame_bit(8'hA5, i / 4));
      end
      n_cmp++;
      if (mem_rdata[0] !== (i != 0)) begin
        n_bad++; $display("FAIL frame_busy slot=%0d got=%b want=%b", i, mem_rdata[0], (i != 0));
      end
    end
    @(negedge clk);
    n_cmp++; if (mem_rdata[0] !== 1'b1) begin n_bad++; $display("FAIL busy_last_stop got=%b want=1", mem_rdata[0]); end
    @(negedge clk);
    n_cmp++; if (mem_rdata[0] !== 1'b0) begin n_bad++; $display("FAIL busy_after_frame got=%b want=0", mem_rdata[0]); end
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL idle_after_frame got=%b want=1", uart_tx); end
    sel = 1'b0; mem_rstrb = 1'b0;
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    bus_write(4'h8, 32'd1000, 4'b0011);
    for (int i = 0; i < 17; i++) bus_write(4'h0, 32'(i), 4'b0001);
    bus_read(4'h4, d);
    n_cmp++; if (d !== 32'h0000_1003) begin n_bad++; $display("FAIL fifo_full_status got=%h want=00001003", d); end
    bus_write(4'h0, 32'h77, 4'b0001);
    bus_read(4'h4, d);
    n_cmp++; if (d !== 32'h0000_100B) begin n_bad++; $display("FAIL overrun_status got=%h want=0000100b", d); end
    bus_write(4'h4, 32'h0000_0008, 4'b0001);
    bus_read(4'h4, d);
    n_cmp++; if (d !== 32'h0000_1003) begin n_bad++; $display("FAIL overrun_w1c got=%h want=00001003", d); end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    int unsigned t1, t2;
    bit found;
    bus_write(4'h8, 32'd2, 4'b0011);
    bus_write(4'hC, 32'd1, 4'b0001);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_idle_empty got=%b want=1", irq); end
    bus_write(4'h0, 32'h00, 4'b0001);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (uart_tx === 1'b0) found = 1'b1; else @(negedge clk);
    end
    t1 = cyc;
    n_cmp++; if (!found) begin n_bad++; $display("FAIL first_start_timeout got=none want=fall"); end
    bus_write(4'h0, 32'hFF, 4'b0001);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (uart_tx === 1'b1) found = 1'b1; else @(negedge clk);
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL first_stop_timeout got=none want=rise"); end
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (uart_tx === 1'b0) found = 1'b1; else @(negedge clk);
    end
    t2 = cyc;
    n_cmp++; if (!found) begin n_bad++; $display("FAIL second_start_timeout got=none want=fall"); end
    n_cmp++; if (t2 - t1 !== 32'd21) begin n_bad++; $display("FAIL frame_spacing got=%0d want=21", t2 - t1); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_during_frame got=%b want=0", irq); end
    repeat (19) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_last_stop got=%b want=0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_after_stop got=%b want=1", irq); end
  endtask

  task automatic test_read_hold();
    logic [31:0] d;
    apply_reset();
    bus_read(4'h8, d);
    n_cmp++; if (d !== 32'h0000_0364) begin n_bad++; $display("FAIL read_baud got=%h want=00000364", d); end
    repeat (5) @(negedge clk);
    n_cmp++; if (mem_rdata !== 32'h0000_0364) begin n_bad++; $display("FAIL rdata_hold got=%h want=00000364", mem_rdata); end
    @(negedge clk);
    sel = 1'b0; mem_addr = 4'h4; mem_rstrb = 1'b1;
    @(negedge clk);
    mem_rstrb = 1'b0;
    n_cmp++; if (mem_rdata !== 32'h0000_0364) begin n_bad++; $display("FAIL rdata_unselected got=%h want=00000364", mem_rdata); end
    bus_read(4'h0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL read_txdata got=%h want=0", d); end
    bus_read(4'h4, d);
    n_cmp++; if (d !== 32'h0000_0004) begin n_bad++; $display("FAIL read_status got=%h want=00000004", d); end
  endtask

  task automatic test_baud_div();
    logic [31:0] d;
    bus_write(4'h8, 32'd0, 4'b0011);
    bus_read(4'h8, d);
    n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL baud_clamp got=%0d want=2", d); end
    bus_write(4'h8, 32'h0000_0100, 4'b0010);
    bus_read(4'h8, d);
    n_cmp++; if (d !== 32'h0000_0102) begin n_bad++; $display("FAIL baud_lane1 got=%h want=00000102", d); end
    bus_write(4'h8, 32'd3, 4'b0011);
    bus_write(4'h0, 32'h5A, 4'b0001);
    fork
      begin
        repeat (5) @(negedge clk);
        bus_write(4'h8, 32'd8, 4'b0011);
      end
      begin
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          n_cmp++;
          if (uart_tx !== frame_bit(8'h5A, i / 3)) begin
            n_bad++; $display("FAIL frame_5a slot=%0d got=%b want=%b", i, uart_tx, frame_bit(8'h5A, i / 3));
          end
        end
      end
    join
    bus_read(4'h8, d);
    n_cmp++; if (d !== 32'd8) begin n_bad++; $display("FAIL baud_midframe_rd got=%0d want=8", d); end
    bus_write(4'h0, 32'hFF, 4'b0001);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_cmp++;
      if (uart_tx !== (i == 8)) begin
        n_bad++; $display("FAIL new_div_start slot=%0d got=%b want=%b", i, uart_tx, (i == 8));
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_frame();
    test_overrun();
    test_back_to_back();
    test_read_hold();
    test_baud_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
